cur_block_buffer: RTL and testbench

- Parametrised double-buffered store for the current (reference) block feeding the motion-estimation PE array.
- One bank (active) drives the full block on cur_out. The other bank (shadow) is filled from the pixel stream using a valid/ready handshake.
- next_block swaps the banks. With STAGGER=1 the swap is a row-staggered handoff: row r moves to the new block r cycles after the swap, matching a systolic array's skew. Requests made before the shadow bank is full are rejected and flagged.

---
 rtl/cur_block_buffer.sv | 182 ++++++++++++++++++
 tb/tb_cur_block_buffer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cur_block_buffer.sv
// ---------------------------------------------------------------------------
// cur_block_buffer
//
// Double-buffered store for the current (reference) block that feeds the
// motion-estimation PE array. The active bank drives the whole block on
// cur_out while the shadow bank is refilled from a valid/ready pixel stream.
// A next_block request swaps the banks once the shadow bank is full. With
// STAGGER=1 the swap is a row-staggered handoff: row r shows the new block
// r cycles after the swap, matching the skew of a systolic array.
//
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   cur_in      input beat of IN_PIX pixels, pixel 0 in the LSBs
//   in_valid    cur_in holds a valid beat
//   in_ready    beat is accepted when in_valid & in_ready at the clock edge
//   next_block  single-cycle swap request
//   cur_out     full block, pixel (r,c) at bit offset (r*BLK_W+c)*PIX_W
//   out_valid   cur_out holds a complete block
//   need_cur    shadow bank not yet full
//   handoff     staggered handoff in progress
//   swap_miss   one-cycle pulse: a next_block request was rejected
// ---------------------------------------------------------------------------
module cur_block_buffer #(
    parameter int PIX_W   = 8,
    parameter int BLK_W   = 8,
    parameter int BLK_H   = 8,
    parameter int IN_PIX  = 4,
    parameter int STAGGER = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [IN_PIX*PIX_W-1:0]        cur_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           next_block,
    output logic [BLK_W*BLK_H*PIX_W-1:0]   cur_out,
    output logic                           out_valid,
    output logic                           need_cur,
    output logic                           handoff,
    output logic                           swap_miss
);

    localparam int NPIX   = BLK_W * BLK_H;
    localparam int BEATS  = NPIX / IN_PIX;
    localparam int BPR    = BLK_W / IN_PIX;
    localparam int WCNT_W = $clog2(BEATS + 1);
    localparam int HS_W   = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int ROW_W  = BLK_W * PIX_W;

    // A single-row block has nothing to stagger, so it never enters handoff.
    localparam bit DO_HANDOFF = (STAGGER != 0) && (BLK_H > 1);

    typedef enum logic {
        ST_IDLE,
        ST_HANDOFF
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [HS_W-1:0]         hs;
    logic [HS_W-1:0]         hs_next;

    logic [NPIX*PIX_W-1:0]   bank0;
    logic [NPIX*PIX_W-1:0]   bank1;
    logic                    act;
    logic [WCNT_W-1:0]       wcnt;

    logic                    full;
    logic                    gate;
    logic                    accept;
    logic                    swap_ok;
    logic                    hs_last;
    logic [NPIX*PIX_W-1:0]   act_bank;
    logic [NPIX*PIX_W-1:0]   old_bank;

    assign full     = (wcnt == WCNT_W'(BEATS));
    assign need_cur = ~full;

    // During handoff the shadow bank still drives every row below hs, so a
    // beat may only land in a row that has already switched to the new bank.
    assign gate     = handoff && ((int'(wcnt) / BPR) > int'(hs));
    assign in_ready = need_cur & ~gate;
    assign accept   = in_valid & in_ready;

    // The request is judged on the registered full flag, so a request in the
    // cycle that accepts the final beat is still rejected.
    assign swap_ok  = next_block & full;
    assign hs_last  = (int'(hs) == BLK_H - 2);

    assign act_bank = act ? bank1 : bank0;
    assign old_bank = act ? bank0 : bank1;

    // Handoff state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            hs    <= '0;
        end else begin
            state <= state_next;
            hs    <= hs_next;
        end
    end

    // Handoff next-state logic: hs walks the row boundary down the block.
    always_comb begin
        state_next = state;
        hs_next    = hs;
        case (state)
            ST_IDLE: begin
                if (swap_ok && DO_HANDOFF) begin
                    state_next = ST_HANDOFF;
                    hs_next    = '0;
                end
            end
            ST_HANDOFF: begin
                if (hs_last) begin
                    state_next = ST_IDLE;
                    hs_next    = '0;
                end else begin
                    hs_next = hs + HS_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                hs_next    = '0;
            end
        endcase
    end

    // Handoff outputs.
    always_comb begin
        handoff = (state == ST_HANDOFF);
    end

    // Bank storage, write counter and swap bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0     <= '0;
            bank1     <= '0;
            act       <= 1'b0;
            wcnt      <= '0;
            out_valid <= 1'b0;
            swap_miss <= 1'b0;
        end else begin
            swap_miss <= next_block & ~full;

            if (swap_ok) begin
                act       <= ~act;
                out_valid <= 1'b1;
                wcnt      <= '0;
            end else if (accept) begin
                wcnt <= wcnt + WCNT_W'(1);
            end

            // Each pixel slot owns one beat index; only the matching beat
            // writes it, and only into the bank that is not active.
            if (accept) begin
                for (int p = 0; p < NPIX; p++) begin
                    if (WCNT_W'(p / IN_PIX) == wcnt) begin
                        if (act) begin
                            bank0[p*PIX_W +: PIX_W] <= cur_in[(p % IN_PIX)*PIX_W +: PIX_W];
                        end else begin
                            bank1[p*PIX_W +: PIX_W] <= cur_in[(p % IN_PIX)*PIX_W +: PIX_W];
                        end
                    end
                end
            end
        end
    end

    // Output mux: rows past hs keep showing the old bank during handoff.
    always_comb begin
        cur_out = act_bank;
        for (int r = 0; r < BLK_H; r++) begin
            if (handoff && (r > int'(hs))) begin
                cur_out[r*ROW_W +: ROW_W] = old_bank[r*ROW_W +: ROW_W];
            end
        end
    end

endmodule

// File: tb/tb_cur_block_buffer.sv
// ---------------------------------------------------------------------------
// tb_cur_block_buffer
//
// Self-checking bench for cur_block_buffer. Two instances are built, one
// staggered and one flat; a selector picks which one is being exercised.
// Expected outputs come from a block-level model: three pixel arrays (new,
// old, pending), a beat count, and the number of cycles since the last swap.
// ---------------------------------------------------------------------------
module tb_cur_block_buffer;

    localparam int PIX_W = 8;
    localparam int BLK_W = 8;
    localparam int BLK_H = 8;
    localparam int IN_PIX = 4;
    localparam int NPIX = BLK_W * BLK_H;
    localparam int BEATS = NPIX / IN_PIX;
    localparam int BPR = BLK_W / IN_PIX;
    localparam int OUT_W = NPIX * PIX_W;
    localparam int IN_W = IN_PIX * PIX_W;
    localparam int FAR = 1000;

    logic clk = 1'b0;
    logic rst_n;

    logic [IN_W-1:0]  cur_in1, cur_in0;
    logic             in_valid1, in_valid0;
    logic             next_block1, next_block0;
    logic             in_ready1, in_ready0;
    logic [OUT_W-1:0] cur_out1, cur_out0;
    logic             out_valid1, out_valid0;
    logic             need_cur1, need_cur0;
    logic             handoff1, handoff0;
    logic             swap_miss1, swap_miss0;

    always #5 clk = ~clk;

    cur_block_buffer #(
        .PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .IN_PIX(IN_PIX), .STAGGER(1)
    ) u_stag (
        .clk(clk), .rst_n(rst_n), .cur_in(cur_in1), .in_valid(in_valid1),
        .in_ready(in_ready1), .next_block(next_block1), .cur_out(cur_out1),
        .out_valid(out_valid1), .need_cur(need_cur1), .handoff(handoff1),
        .swap_miss(swap_miss1)
    );

    cur_block_buffer #(
        .PIX_W(PIX_W), .BLK_W(BLK_W), .BLK_H(BLK_H), .IN_PIX(IN_PIX), .STAGGER(0)
    ) u_flat (
        .clk(clk), .rst_n(rst_n), .cur_in(cur_in0), .in_valid(in_valid0),
        .in_ready(in_ready0), .next_block(next_block0), .cur_out(cur_out0),
        .out_valid(out_valid0), .need_cur(need_cur0), .handoff(handoff0),
        .swap_miss(swap_miss0)
    );

    // Reference model state.
    int  new_blk [NPIX];
    int  old_blk [NPIX];
    int  pend    [NPIX];
    int  src     [NPIX];
    int  beats;
    int  since;
    bit  ov;
    bit  miss;
    bit  stag;
    bit  sel;

    int  checks;
    int  errors;

    function automatic void model_reset();
        for (int p = 0; p < NPIX; p++) begin
            new_blk[p] = 0;
            old_blk[p] = 0;
            pend[p]    = 0;
        end
        beats = 0;
        since = FAR;
        ov    = 1'b0;
        miss  = 1'b0;
    endfunction

    function automatic bit exp_hand();
        return stag && (since <= BLK_H - 2);
    endfunction

    function automatic bit exp_rdy();
        return (beats < BEATS) && !(exp_hand() && ((beats / BPR) > since));
    endfunction

    // Row r shows the new block once r cycles have passed since the swap.
    function automatic logic [OUT_W-1:0] exp_out();
        logic [OUT_W-1:0] e;
        int v;
        e = '0;
        for (int p = 0; p < NPIX; p++) begin
            v = (!stag || since >= (p / BLK_W)) ? new_blk[p] : old_blk[p];
            e[p*PIX_W +: PIX_W] = v[PIX_W-1:0];
        end
        return e;
    endfunction

    function automatic void new_src(input bit ramp);
        for (int p = 0; p < NPIX; p++) begin
            src[p] = ramp ? p : int'($urandom_range(0, 255));
        end
    endfunction

    // Advance the model across one clock edge with the given inputs.
    function automatic void model_edge(input bit v, input bit nb);
        bit full;
        bit acc;
        full = (beats == BEATS);
        acc  = v && exp_rdy();
        miss = nb && !full;
        if (acc) begin
            for (int i = 0; i < IN_PIX; i++) begin
                pend[beats*IN_PIX + i] = src[beats*IN_PIX + i];
            end
            beats++;
        end
        if (nb && full) begin
            for (int p = 0; p < NPIX; p++) begin
                old_blk[p] = new_blk[p];
                new_blk[p] = pend[p];
            end
            ov    = 1'b1;
            beats = 0;
            since = 0;
        end else if (since < FAR) begin
            since++;
        end
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [OUT_W-1:0] obs,
                             input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check_bit("in_ready",  sel ? in_ready1  : in_ready0,  exp_rdy());
        check_bit("need_cur",  sel ? need_cur1  : need_cur0,  beats < BEATS);
        check_bit("out_valid", sel ? out_valid1 : out_valid0, ov);
        check_bit("handoff",   sel ? handoff1   : handoff0,   exp_hand());
        check_bit("swap_miss", sel ? swap_miss1 : swap_miss0, miss);
        check_vec("cur_out",   sel ? cur_out1   : cur_out0,   exp_out());
    endtask

    task automatic drive(input bit v, input bit nb);
        logic [IN_W-1:0] beat;
        int px;
        beat = '0;
        if (beats < BEATS) begin
            for (int i = 0; i < IN_PIX; i++) begin
                px = src[beats*IN_PIX + i];
                beat[i*PIX_W +: PIX_W] = px[PIX_W-1:0];
            end
        end
        cur_in1     = sel ? beat : '0;
        in_valid1   = sel ? v : 1'b0;
        next_block1 = sel ? nb : 1'b0;
        cur_in0     = sel ? '0 : beat;
        in_valid0   = sel ? 1'b0 : v;
        next_block0 = sel ? 1'b0 : nb;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic applyStimulus(input bit v, input bit nb);
        drive(v, nb);
        checkOutput();
        @(posedge clk);
        model_edge(v, nb);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit d10;
        bit d15;
        bit v;
        bit nb;

        checks = 0;
        errors = 0;
        sel    = 1'b1;
        stag   = 1'b1;
        new_src(1'b1);
        model_reset();
        drive(1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput();
        rst_n = 1'b1;

        // Fill block A with the pixel index ramp; nothing is shown yet.
        repeat (BEATS) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);

        // Swap A in and stream block B during the staggered handoff,
        // with a rejected request while the handoff is still running.
        new_src(1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, k == 2);

        // Swap B in, then fill C with random bubbles and two early requests.
        applyStimulus(1'b0, 1'b1);
        new_src(1'b0);
        d10 = 1'b0;
        d15 = 1'b0;
        for (int k = 0; k < 120 && beats < BEATS; k++) begin
            v  = ($urandom_range(0, 3) != 0);
            nb = 1'b0;
            if (beats == 10 && !d10) begin
                nb  = 1'b1;
                d10 = 1'b1;
            end else if (beats == 15 && v && !d15) begin
                nb  = 1'b1;
                d15 = 1'b1;
            end
            applyStimulus(v, nb);
        end
        applyStimulus(1'b0, 1'b0);

        // Swap C in and reset part way through its handoff.
        applyStimulus(1'b0, 1'b1);
        new_src(1'b0);
        repeat (5) applyStimulus(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;

        // A full refill is needed again before the next swap is honoured.
        repeat (BEATS - 1) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (9) applyStimulus(1'b0, 1'b0);

        // Flat instance: every row switches on the swap edge.
        sel  = 1'b0;
        stag = 1'b0;
        drive(1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
        new_src(1'b0);
        repeat (BEATS) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        new_src(1'b0);
        repeat (BEATS) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
